// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS execute stage with E pipe register, forwarding, ALU and multi-cycle mult/div unit.
//   Ports: clk, reset (async active-low), clr (bubble load);
//   D inputs IR_D/PC8_D/RS_D/RT_D/EXT_D; forwarding C_M/WD with selects FA_E/FB_E;
//   outputs IR_E/PC8_E/AO_E/RT_E plus md_start (comb) and md_busy (registered) for the hazard unit.
module ex_stage_md #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic [31:0] IR_D,
  input  logic [31:0] PC8_D,
  input  logic [31:0] RS_D,
  input  logic [31:0] RT_D,
  input  logic [31:0] EXT_D,
  input  logic [31:0] C_M,
  input  logic [31:0] WD,
  input  logic [1:0]  FA_E,
  input  logic [1:0]  FB_E,
  output logic [31:0] IR_E,
  output logic [31:0] PC8_E,
  output logic [31:0] AO_E,
  output logic [31:0] RT_E,
  output logic        md_start,
  output logic        md_busy
);
  localparam int CW = $clog2((MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC) + 1);
  logic [31:0] rs_e, rt_e, ext_e, a, b, hi, lo, md_a, md_b;
  logic [31:0] ua, ub, q, r, quo, rem;
  logic [63:0] prod;
  logic [CW-1:0] cnt;
  logic [1:0] md_op;
  logic [5:0] op, fn;
  logic is_md, is_mthi, is_mtlo, neg_a, neg_b;

  always_ff @(posedge clk or negedge reset)
    if (!reset) {IR_E, PC8_E, rs_e, rt_e, ext_e} <= '0;
    else if (clr) {IR_E, PC8_E, rs_e, rt_e, ext_e} <= '0;
    else {IR_E, PC8_E, rs_e, rt_e, ext_e} <= {IR_D, PC8_D, RS_D, RT_D, EXT_D};

  assign op = IR_E[31:26];
  assign fn = IR_E[5:0];
  assign a = FA_E == 2'd1 ? WD : FA_E == 2'd2 ? C_M : rs_e;
  assign b = FB_E == 2'd1 ? WD : FB_E == 2'd2 ? C_M : rt_e;
  assign RT_E = b;
  // fn 0x18..0x1B share fn[5:2]; fn[1] selects divide, fn[0] selects unsigned
  assign is_md = op == 6'h00 && fn[5:2] == 4'b0110;
  assign is_mthi = op == 6'h00 && fn == 6'h11;
  assign is_mtlo = op == 6'h00 && fn == 6'h13;
  assign md_start = is_md & ~md_busy;

  // one multiplier for both signednesses: sign-extend only for the signed op
  assign prod = {{32{md_a[31] & ~md_op[0]}}, md_a} * {{32{md_b[31] & ~md_op[0]}}, md_b};
  // signed divide via magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0
  assign neg_a = ~md_op[0] & md_a[31];
  assign neg_b = ~md_op[0] & md_b[31];
  assign ua = neg_a ? -md_a : md_a;
  assign ub = neg_b ? -md_b : md_b;
  assign q = ub == '0 ? '0 : ua / ub;
  assign r = ub == '0 ? '0 : ua % ub;
  assign quo = (neg_a ^ neg_b) ? -q : q;
  assign rem = neg_a ? -r : r;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      md_busy <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      md_a <= '0;
      md_b <= '0;
      md_op <= '0;
    end else if (md_busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        md_busy <= 1'b0;
        if (!md_op[1]) {hi, lo} <= prod;
        else if (md_b != '0) begin
          hi <= rem;
          lo <= quo;
        end
      end
    end else if (md_start) begin
      md_a <= a;
      md_b <= b;
      md_op <= fn[1:0];
      cnt <= fn[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
      md_busy <= 1'b1;
    end else if (is_mthi) hi <= a;
    else if (is_mtlo) lo <= a;

  always_comb begin
    AO_E = '0;
    case (op)
      6'h00:
        case (fn)
          6'h21: AO_E = a + b;
          6'h23: AO_E = a - b;
          6'h24: AO_E = a & b;
          6'h25: AO_E = a | b;
          6'h2A: AO_E = {31'b0, $signed(a) < $signed(b)};
          6'h00: AO_E = b << IR_E[10:6];
          6'h10: AO_E = hi;
          6'h12: AO_E = lo;
          default: AO_E = '0;
        endcase
      6'h0D: AO_E = a | ext_e;
      6'h0F: AO_E = ext_e;
      6'h23, 6'h2B: AO_E = a + ext_e;
      6'h03: AO_E = PC8_E;
      default: AO_E = '0;
    endcase
  end
endmodule
